// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word register file: DMux8Way load decode, WIDTH-bit word registers, 8-way read mux.
// Read is combinational from address; writes land on the rising clock edge (no write-through).

module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    // AND form keeps every output at 0 whenever in is 0, even with an unknown select.
    assign a = in & (sel == 3'd0);
    assign b = in & (sel == 3'd1);
    assign c = in & (sel == 3'd2);
    assign d = in & (sel == 3'd3);
    assign e = in & (sel == 3'd4);
    assign f = in & (sel == 3'd5);
    assign g = in & (sel == 3'd6);
    assign h = in & (sel == 3'd7);
endmodule

module mux8way #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end
endmodule

module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);
    logic             en_a, en_b, en_c, en_d, en_e, en_f, en_g, en_h;
    logic [7:0]       load_en;
    logic [WIDTH-1:0] word_q [8];
    logic [WIDTH-1:0] word_d [8];

    dmux8way u_dmux (
        .in  (load),
        .sel (address),
        .a   (en_a),
        .b   (en_b),
        .c   (en_c),
        .d   (en_d),
        .e   (en_e),
        .f   (en_f),
        .g   (en_g),
        .h   (en_h)
    );

    assign load_en = {en_h, en_g, en_f, en_e, en_d, en_c, en_b, en_a};

    // Each word is a Register: every bit recirculates unless its word enable is set.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            word_d[k] = word_q[k];
            if (load_en[k]) begin
                word_d[k] = in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                word_q[k] <= word_d[k];
            end
        end
    end

    mux8way #(.WIDTH(WIDTH)) u_mux (
        .a   (word_q[0]),
        .b   (word_q[1]),
        .c   (word_q[2]),
        .d   (word_q[3]),
        .e   (word_q[4]),
        .f   (word_q[5]),
        .g   (word_q[6]),
        .h   (word_q[7]),
        .sel (address),
        .out (out)
    );
endmodule

// File: doc/ram8.md
Name: ram8

Overview:
- Eight-word register file: the storage stage that sits directly downstream of DMux8Way.
- A DMux8Way instance fans the single `load` strobe out to eight per-word load enables, selected by `address`.
- The eight words are read back through an 8-way word mux.
- `ram8` is the leaf memory tile that RAM64 and larger RAMs are built from.
- Per-word storage is a WIDTH-bit Register: DFF bits, each with a load-select mux.

Parameters:
- WIDTH, 16, data word width in bits; must be ≥1.

Ports:
- clk  input  1  rising-edge clock for all storage.
- rst_n  input  1  asynchronous active-low reset; clears every word.
- in  input  WIDTH  write data.
- load  input  1  write enable, sampled on the rising edge of `clk`.
- address  input  3  word select for both write and read (0..7).
- out  output  WIDTH  read data, equal to `word[address]`.

Behaviour:
- Storage: eight registers, `word[0..7]`, each WIDTH bits.
- Reset, asynchronous:
  - `rst_n`=0 clears all eight words to 0 immediately, without waiting for a clock edge.
  - `out` reads 0 for any address while `rst_n`=0.
  - Reset dominates `load`: no write occurs on any edge while `rst_n`=0.
- Release of reset:
  - `rst_n` 0→1 takes effect asynchronously.
  - The first write can land on the first rising edge after release.
  - A `load` coincident with the release edge must not corrupt any word other than `word[address]`; the bench avoids this case.
- Load decode:
  - `load` drives the DMux8Way input; `address` drives its select.
  - Exactly one per-word enable equals `load`; the other seven are 0.
  - `address` value k enables `word[k]`, where the DMux outputs a..h map to `word[0]`..`word[7]`.
- Write:
  - On a rising `clk` edge with `rst_n`=1 and `load`=1, `word[address]` ← `in`.
  - All other words hold their values.
  - With `load`=0, every word holds.
- Read:
  - Combinational: `out` = `word[address]` at all times, with zero-cycle latency from an `address` change.
- Write latency:
  - A written value appears on `out` after the clock edge, not before.
  - During the cycle in which `load`=1, `out` shows the old contents of `word[address]`. This is Hack RAM semantics; there is no write-through.
- Simultaneous events:
  - Changing `address` and `in` with `load`=1 in the same cycle writes the final pre-edge values.
  - Back-to-back writes to the same address: the last write wins, one per edge.
- Boundaries:
  - Address 0 and address 7 are fully independent words; there is no aliasing or wrap.
  - All-ones data (0xFFFF at WIDTH=16) stores and reads back exactly.
- State: no state machine; the state is the 8×WIDTH storage array.
  - A word holds its value indefinitely until it is rewritten or reset.
- X handling:
  - With `load`=0, an unknown `address` or `in` must not modify storage.

Test Plan:
- Async reset:
  - Stimulus: write 0x1234 to address 3, then pull `rst_n` low mid-cycle, between clock edges.
  - Required: `out` at address 3 reads 0x0000 before the next edge, and every address 0..7 reads 0 afterwards.
- Write/readback sweep:
  - Stimulus: after reset, write `word[k]` = 0x1111·(k+1) for k = 0..7 (0x1111, 0x2222, …, 0x8888), then set `load`=0 and sweep `address` 0..7.
  - Required: `out` matches each written value, checked with the case-inequality operator `!==`.
- Write isolation:
  - Stimulus: with all words set to 0xAAAA, write 0x5555 to address 5.
  - Required: address 5 reads 0x5555; addresses 0–4, 6 and 7 still read 0xAAAA.
- Write latency:
  - Stimulus: with address 2 holding 0x0F0F, apply `in`=0xF0F0 and `load`=1.
  - Required: `out` reads 0x0F0F before the edge and 0xF0F0 after it.
- Load gating:
  - Stimulus: `load`=0 with `in`=0xFFFF toggled across all addresses for 8 cycles.
  - Required: no word changes.
  - Follow-up: write 0xFFFF then 0x0000 to address 7 on consecutive edges; it reads 0x0000.
- Reset dominance:
  - Stimulus: hold `rst_n`=0 with `load`=1, `address`=1, `in`=0xBEEF for 3 edges, then release.
  - Required: address 1 reads 0x0000; the next edge with `load`=1 stores 0xBEEF.
